// File: rtl/cic_comb_decim.sv
// cic_comb_decim: decimating comb section of a CIC decimator.
// Takes every R-th valid integrator sample, then runs N comb stages
// (y = x - x delayed by M decimated samples) with wrapping DATA_W math.
// It emits a one-cycle out_dv with the top OUT_W bits of the result.
// Build option: define CIC_COMB_ROUND_EN to round half up instead of
// truncating when OUT_W < DATA_W. Latency does not depend on the option.
module cic_comb_decim #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned OUT_W  = 10,
  parameter int unsigned R      = 4,
  parameter int unsigned N      = 3,
  parameter int unsigned M      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_dv,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_dv,
  output logic [OUT_W-1:0]  data_out
);

  localparam int unsigned       PH_W    = $clog2(R);
  localparam logic [PH_W-1:0]   PH_LAST = PH_W'(R - 1);
  localparam int unsigned       SH      = DATA_W - OUT_W;

  // x[0] is the captured sample. x[k] (k >= 1) is the registered result of
  // comb stage k. The last comb stage N is not held in its own register.
  // Its difference goes straight into the output register, so the output
  // appears N+1 clocks after capture. dly[k] is the delay line of stage k+1.
  logic [PH_W-1:0]   ph;
  logic              capture;
  logic [DATA_W-1:0] x   [N];
  logic              v   [N];
  logic [DATA_W-1:0] dly [N][M];
  logic [DATA_W-1:0] comb_n;
  logic [OUT_W-1:0]  f_out;

  assign capture = in_dv && (ph == PH_LAST);

  // Combinational difference of the final comb stage.
  always_comb begin
    comb_n = x[N-1] - dly[N-1][M-1];
  end

`ifdef CIC_COMB_ROUND_EN
  generate
    if (SH == 0) begin : g_full
      assign f_out = comb_n;
    end else begin : g_round
      logic [DATA_W-1:0] rnd_sum;
      // Add half an output LSB with wrap, then keep the top OUT_W bits.
      // Keeping the top bits is the same as an arithmetic shift right by SH.
      assign rnd_sum = comb_n + (DATA_W'(1) << (SH - 1));
      assign f_out   = rnd_sum[DATA_W-1 -: OUT_W];
    end
  endgenerate
`else
  assign f_out = comb_n[DATA_W-1 -: OUT_W];
`endif

  // Decimation phase counter. It advances only on valid input samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      ph <= '0;
    end else if (in_dv) begin
      ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
    end
  end

  // Capture register, comb pipeline, delay lines and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < N; k++) begin
        x[k] <= '0;
        v[k] <= 1'b0;
        for (int unsigned j = 0; j < M; j++) begin
          dly[k][j] <= '0;
        end
      end
      out_dv   <= 1'b0;
      data_out <= '0;
    end else begin
      v[0] <= capture;
      if (capture) begin
        x[0] <= data_in;
      end

      for (int unsigned k = 0; k < N; k++) begin
        if (v[k]) begin
          dly[k][0] <= x[k];
          for (int unsigned j = 1; j < M; j++) begin
            dly[k][j] <= dly[k][j-1];
          end
        end
      end

      for (int unsigned k = 1; k < N; k++) begin
        v[k] <= v[k-1];
        if (v[k-1]) begin
          x[k] <= x[k-1] - dly[k-1][M-1];
        end
      end

      out_dv <= v[N-1];
      if (v[N-1]) begin
        data_out <= f_out;
      end
    end
  end

endmodule

// File: tb/tb_cic_comb_decim.sv
// tb_cic_comb_decim: self-checking bench for cic_comb_decim.
// Two instances share the stimulus. One has full width (OUT_W=14) and one
// has the default width (OUT_W=10).
// The reference model keeps the history of captured samples. It computes
// each comb output as the N-th order M-lag difference using binomial
// weights, wrapped to 14 bits, and schedules it N+1 cycles after capture.
module tb_cic_comb_decim;

  localparam int TR = 4;
  localparam int TN = 3;
  localparam int TM = 1;

  logic        clk;
  logic        reset;
  logic        in_dv;
  logic [13:0] data_in;
  logic        out_dv_a;
  logic [13:0] data_out_a;
  logic        out_dv_b;
  logic [9:0]  data_out_b;

  cic_comb_decim #(.DATA_W(14), .OUT_W(14), .R(TR), .N(TN), .M(TM)) u_full (
    .clk(clk), .reset(reset), .in_dv(in_dv), .data_in(data_in),
    .out_dv(out_dv_a), .data_out(data_out_a)
  );

  cic_comb_decim #(.DATA_W(14), .OUT_W(10), .R(TR), .N(TN), .M(TM)) u_trunc (
    .clk(clk), .reset(reset), .in_dv(in_dv), .data_in(data_in),
    .out_dv(out_dv_b), .data_out(data_out_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          due;
    logic [13:0] y;
  } pend_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          mph   = 0;
  int          hist[$];
  pend_t       pend[$];
  logic [13:0] exp_a = '0;
  logic [9:0]  exp_b = '0;
  int          rec_a[$];
  int          rec_b[$];
  int          rec_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int binom(input int n, input int k);
    int c = 1;
    for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
    return c;
  endfunction

  // N-th order difference of the captured history, taken modulo 2^14.
  function automatic logic [13:0] comb_model();
    int acc = 0;
    int idx;
    for (int i = 0; i <= TN; i++) begin
      idx = hist.size() - 1 - i * TM;
      if (idx >= 0) acc += ((i % 2 == 0) ? 1 : -1) * binom(TN, i) * hist[idx];
    end
    return acc[13:0];
  endfunction

  // 14-bit value to 10 bits: floor(y/16), or floor((y+8)/16) with rounding.
  function automatic logic [9:0] f10(input logic [13:0] y);
    int v;
    int q;
    v = int'($signed(y));
`ifdef CIC_COMB_ROUND_EN
    v = v + 8;
    if (v > 8191) v = v - 16384;
`endif
    q = (v >= 0) ? v / 16 : -((-v + 15) / 16);
    return q[9:0];
  endfunction

  function automatic int get_q(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'h0DEAD;
  endfunction

  task automatic clr_rec();
    rec_a.delete();
    rec_b.delete();
    rec_cyc.delete();
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, update model.
  task automatic step(input logic dv, input logic [13:0] din, input logic rst);
    pend_t p;
    logic  edv;
    in_dv   = dv;
    data_in = din;
    reset   = rst;
    @(negedge clk);
    edv = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      p     = pend.pop_front();
      edv   = 1'b1;
      exp_a = p.y;
      exp_b = f10(p.y);
    end
    chk("dv_full",   out_dv_a,   edv);
    chk("dout_full", data_out_a, exp_a);
    chk("dv_10b",    out_dv_b,   edv);
    chk("dout_10b",  data_out_b, exp_b);
    if (out_dv_a === 1'b1) begin
      rec_a.push_back(int'(data_out_a));
      rec_b.push_back(int'(data_out_b));
      rec_cyc.push_back(cyc);
    end
    if (rst) begin
      mph = 0;
      hist.delete();
      pend.delete();
      exp_a = '0;
      exp_b = '0;
    end else if (dv) begin
      if (mph == TR - 1) begin
        hist.push_back(int'(din));
        p.due = cyc + TN + 1;
        p.y   = comb_model();
        pend.push_back(p);
      end
      mph = (mph + 1) % TR;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
  endtask

  initial begin
    int c0;
    logic [13:0] rv;
    reset   = 1'b1;
    in_dv   = 1'b0;
    data_in = '0;
    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    step(1'b0, '0, 1'b0);

    // Ramp, continuous valid
    clr_rec();
    c0 = cyc;
    for (int i = 0; i < 20; i++) step(1'b1, 14'(i), 1'b0);
    chk("t1_first_cycle", get_q(rec_cyc, 0), c0 + 7);
    chk("t1_out0", get_q(rec_a, 0), 3);
    chk("t1_out1", get_q(rec_a, 1), 16382);
    chk("t1_out2", get_q(rec_a, 2), 16383);
    chk("t1_out3", get_q(rec_a, 3), 0);

    // Constant 1600
    do_reset();
    clr_rec();
    for (int i = 0; i < 20; i++) step(1'b1, 14'd1600, 1'b0);
    chk("t2_out0", get_q(rec_b, 0), 100);
    chk("t2_out1", get_q(rec_b, 1), 824);
    chk("t2_out2", get_q(rec_b, 2), 100);
    chk("t2_out3", get_q(rec_b, 3), 0);
    chk("t2_period", get_q(rec_cyc, 1) - get_q(rec_cyc, 0), 4);

    // Gapped valid
    do_reset();
    clr_rec();
    c0 = cyc;
    step(1'b1, 14'd5, 1'b0);
    step(1'b0, 14'd0, 1'b0);
    step(1'b0, 14'd0, 1'b0);
    step(1'b1, 14'd5, 1'b0);
    step(1'b1, 14'd5, 1'b0);
    step(1'b0, 14'd0, 1'b0);
    step(1'b1, 14'd5, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
    chk("t3_count", rec_b.size(), 1);
    chk("t3_cycle", get_q(rec_cyc, 0), c0 + 10);
    chk("t3_value", get_q(rec_b, 0), 0);

    // Rounding at y = 24 and y = -8
    for (int t = 0; t < 2; t++) begin
      rv = (t == 0) ? 14'd24 : 14'd16376;
      do_reset();
      clr_rec();
      for (int i = 0; i < 3; i++) step(1'b1, '0, 1'b0);
      step(1'b1, rv, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0);
      chk("t4_full", get_q(rec_a, 0), int'(rv));
`ifdef CIC_COMB_ROUND_EN
      chk("t4_round", get_q(rec_b, 0), (t == 0) ? 2 : 0);
`else
      chk("t4_trunc", get_q(rec_b, 0), (t == 0) ? 1 : 1023);
`endif
    end

    // Wrap: 8191 then -8192
    do_reset();
    clr_rec();
    for (int i = 0; i < 3; i++) step(1'b1, '0, 1'b0);
    step(1'b1, 14'd8191, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, '0, 1'b0);
    step(1'b1, 14'd8192, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0);
    chk("t5_out0", get_q(rec_a, 0), 8191);
    chk("t5_out1", get_q(rec_a, 1), 3);

    // Reset one cycle after a capture
    do_reset();
    clr_rec();
    for (int i = 0; i < 4; i++) step(1'b1, 14'(i), 1'b0);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0);
    chk("t6_no_output", rec_a.size(), 0);
    for (int i = 0; i < 16; i++) step(1'b1, 14'(i), 1'b0);
    chk("t6_out0", get_q(rec_a, 0), 3);
    chk("t6_out1", get_q(rec_a, 1), 16382);
    chk("t6_out2", get_q(rec_a, 2), 16383);

    // Random valid pattern, data and occasional reset
    for (int i = 0; i < 1500; i++) begin
      step(1'b1 && ($urandom_range(0, 9) < 7),
           14'($urandom),
           1'b1 && ($urandom_range(0, 199) == 0));
    end
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cic_comb_decim.md
# cic_comb_decim

Decimating comb section of the CIC decimation filter. Sits directly downstream of the `cic_i` integrator block and consumes its 14-bit `data_out` and valid strobe. Downsamples by R, runs N pipelined comb (differentiator) stages with differential delay M, and emits a one-cycle-valid output word at the decimated rate.

## Interface

Parameters:
- `DATA_W`, default 14: input word width; matches integrator output width; internal comb width.
- `OUT_W`, default 10: output width, `OUT_W <= DATA_W`; the top `OUT_W` bits of the comb result are kept.
- `R`, default 4: decimation factor, `>= 2`.
- `N`, default 3: number of comb stages, `>= 1`.
- `M`, default 1: differential delay in decimated samples, 1 or 2.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `in_dv`  in  1: input sample valid, from the integrator.
- `data_in`  in  DATA_W: integrator output, two's complement.
- `out_dv`  out  1: decimated output valid, one-cycle pulse.
- `data_out`  out  OUT_W: comb output, two's complement.

## Operation

- Phase counter `ph`, range 0..R-1:
  - Advances only on `in_dv`; wraps from R-1 to 0.
  - Gaps in `in_dv` freeze it.
- Capture:
  - When `in_dv && ph==R-1`, `data_in` is registered into the stage-0 register and the stage-0 valid bit is set for one cycle.
  - All other samples are discarded.
- Comb stage k (1..N):
  - On stage k-1 valid, computes `y_k = x_{k-1} - d_k[M-1]` modulo 2^DATA_W.
  - Registers `y_k` and shifts `x_{k-1}` into its M-deep delay line `d_k`.
  - Asserts stage k valid for one cycle.
  - Delay lines and result registers hold when not strobed.
- Arithmetic:
  - All comb math is DATA_W wide with silent two's-complement wrap. Wrap is required for CIC correctness, so there is no saturation.
- Output:
  - On stage N valid, `data_out <= f(y_N)` and `out_dv <= 1`.
  - `f` is selected per Configuration.
  - `out_dv` is 0 in every other cycle, and `data_out` holds its last value.
- Reset clears to 0: `ph`, all valid bits, all delay lines, all stage registers, `data_out`, `out_dv`.
- Reset mid-operation:
  - In-flight samples are dropped.
  - The first output after reset sees zero history.
  - `out_dv` stays 0 until a new capture has traversed the pipeline.

## Timing

- Capture in cycle T (`in_dv=1`, `ph=R-1`) gives `out_dv=1` in cycle T+N+1. Latency is N+1 clocks, and is independent of input gaps after capture.
- Throughput: at most one output per R valid inputs. With continuous `in_dv`, `out_dv` is periodic with period R.
- Since `R >= 2`, consecutive captures never overlap inside a stage. There are no stall or backpressure inputs.
- `reset` asserted in cycle T forces all outputs to 0 from cycle T+1. It takes precedence over `in_dv` in the same cycle.

## Configuration

- `CIC_COMB_ROUND_EN` defined:
  - `f(y) = (y + 2^(DATA_W-OUT_W-1)) >>> (DATA_W-OUT_W)`, round half up; the add wraps modulo 2^DATA_W.
  - When `OUT_W == DATA_W`, no rounding is done and `f(y) = y`.
- Undefined:
  - `f(y) = y[DATA_W-1 -: OUT_W]`, plain truncation toward −∞.
- Latency is identical in both builds.

## Test plan

All cases use the defaults DATA_W=14, R=4, N=3, M=1, except case 1.

1. Ramp with continuous `in_dv`, `data_in`=0,1,2,…, and OUT_W=DATA_W:
   - Captures are 3, 7, 11, 15.
   - Outputs are 3, −2 (16382), −1 (16383), 0, 0…
   - First `out_dv` occurs 4 cycles after the 4th valid input.
2. Constant 1600 with `in_dv` continuous:
   - Raw comb outputs are 1600, −3200, 1600, 0, 0.
   - Truncated `data_out` = 100, −200 (824 as 10-bit), 100, 0.
   - `out_dv` period is 4.
3. Gapped `in_dv` (1,0,0,1,1,0,1) with `data_in`=5 on each valid:
   - Exactly one `out_dv`, N+1 cycles after the 4th valid.
   - `data_out` = 5>>4 = 0 (truncation build).
4. Rounding, with the comb result forced to y=24:
   - With `CIC_COMB_ROUND_EN`: `data_out`=2.
   - Without: `data_out`=1.
   - Also y=−8: 0 with rounding, −1 (1023) without.
5. Wrap, with successive captures 8191 then −8192 (8192):
   - Stage-1 difference wraps to 1.
   - No X or saturation appears on `data_out`.
6. Reset mid-pipeline: assert `reset` one cycle after a capture.
   - `out_dv` stays 0.
   - After release, the ramp test restarts and produces the first-output values of test 1 (3, −2, −1).
